// File: rtl/pc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : pc_pkg                                                     |
// | Brief    : Shared constants for the PC sequencer and its RAS.         |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package pc_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_BOOT  = 2'd0;
    localparam state_t c_ST_FETCH = 2'd1;
    localparam state_t c_ST_HALT  = 2'd2;
    localparam state_t c_ST_TRAP  = 2'd3;

    localparam int unsigned c_PC_INC     = 4;
    localparam logic [1:0]  c_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return |(addr_lsbs & c_ALIGN_MASK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : pc_ras                                                     |
// | Brief    : Circular return-address stack; overwrites oldest when full.|
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module pc_ras
    import pc_pkg::*;
#(
    parameter int RAS_DEPTH = 4,
    parameter int DWIDTH    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DWIDTH-1:0] i_push_data,
    output logic [DWIDTH-1:0] o_top,
    output logic              o_empty,
    output logic              o_full
);

    localparam int c_PTR_W = $clog2(RAS_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DWIDTH-1:0]  r_mem [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [c_PTR_W-1:0] w_top_idx;
    logic               w_pop;

    assign w_top_idx = r_wr_ptr - c_PTR_W'(1);
    assign w_pop     = i_pop && !o_empty;
    assign o_top     = r_mem[w_top_idx];
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CNT_W'(RAS_DEPTH));

    // When full, r_wr_ptr already points at the oldest slot, so a plain push overwrites it.
    always_ff @(posedge clk) begin
        if (i_push) begin
            if (w_pop) begin
                r_mem[w_top_idx] <= i_push_data;
            end else begin
                r_mem[r_wr_ptr] <= i_push_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_push && !w_pop) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (!o_full) begin
                r_count <= r_count + c_CNT_W'(1);
            end
        end else if (w_pop && !i_push) begin
            r_wr_ptr <= w_top_idx;
            r_count  <= r_count - c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : pc_sequencer                                               |
// | Brief    : Fetch PC generator with trap/mret, redirects and a RAS.    |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                DWIDTH       = 32,
    parameter logic [DWIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [DWIDTH-1:0] TRAP_VECTOR  = 'h100,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core,
    input  logic              Run,
    input  logic              Fetch_Ready,
    input  logic              Redirect_Valid,
    input  logic [DWIDTH-1:0] Redirect_Target,
    input  logic              Call_Valid,
    input  logic              Ret_Predict,
    input  logic              Trap_Valid,
    input  logic              Mret_Valid,
    output logic [DWIDTH-1:0] Program_Count,
    output logic              Fetch_Valid,
    output logic [DWIDTH-1:0] Mepc,
    output logic              Misaligned,
    output logic              Ras_Empty,
    output logic              Ras_Full
);

    state_t            r_state;
    logic [DWIDTH-1:0] r_pc;
    logic [DWIDTH-1:0] r_mepc;
    logic              r_misaligned;

    logic [DWIDTH-1:0] w_pc_inc;
    logic [DWIDTH-1:0] w_ras_top;
    logic              w_active;
    logic              w_take_mret;
    logic              w_take_redir;
    logic              w_take_ret;
    logic              w_redir_bad;
    logic              w_push;
    logic              w_pop;

    assign w_pc_inc     = r_pc + DWIDTH'(c_PC_INC);
    assign w_active     = Run && (r_state == c_ST_FETCH);
    assign w_redir_bad  = is_misaligned(Redirect_Target[1:0]);
    assign w_take_mret  = !Trap_Valid && Mret_Valid;
    assign w_take_redir = !Trap_Valid && !Mret_Valid && Redirect_Valid;
    assign w_take_ret   = !Trap_Valid && !Mret_Valid && !Redirect_Valid &&
                          Ret_Predict && Fetch_Ready && !Ras_Empty;
    // A misaligned call behaves as a trap, so no return address is recorded.
    assign w_push       = w_active && w_take_redir && !w_redir_bad && Call_Valid;
    assign w_pop        = w_active && w_take_ret;

    assign Program_Count = r_pc;
    assign Mepc          = r_mepc;
    assign Misaligned    = r_misaligned;
    assign Fetch_Valid   = (r_state == c_ST_FETCH);

    pc_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .DWIDTH    (DWIDTH)
    ) u_ras (
        .clk         (Clk_Core),
        .rst         (Rst_Core),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_inc),
        .o_top       (w_ras_top),
        .o_empty     (Ras_Empty),
        .o_full      (Ras_Full)
    );

    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            r_state      <= c_ST_BOOT;
            r_pc         <= RESET_VECTOR;
            r_mepc       <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            if (!Run) begin
                if (r_state == c_ST_FETCH) begin
                    r_state <= c_ST_HALT;
                end
            end else begin
                case (r_state)
                    c_ST_BOOT, c_ST_HALT, c_ST_TRAP: r_state <= c_ST_FETCH;
                    c_ST_FETCH: begin
                        if (Trap_Valid) begin
                            r_mepc  <= r_pc;
                            r_pc    <= TRAP_VECTOR;
                            r_state <= c_ST_TRAP;
                        end else if (w_take_mret) begin
                            r_pc <= r_mepc;
                        end else if (w_take_redir) begin
                            if (w_redir_bad) begin
                                r_misaligned <= 1'b1;
                                r_mepc       <= Redirect_Target;
                                r_pc         <= TRAP_VECTOR;
                                r_state      <= c_ST_TRAP;
                            end else begin
                                r_pc <= Redirect_Target;
                            end
                        end else if (w_take_ret) begin
                            r_pc <= w_ras_top;
                        end else if (Fetch_Ready) begin
                            r_pc <= w_pc_inc;
                        end
                    end
                    default: r_state <= c_ST_BOOT;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
